// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART RX frame controller.
// UART_RX_FRAME_CSUM_EN adds the CSUM state to the state encoding.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
`ifdef UART_RX_FRAME_CSUM_EN
        CSUM    = 3'd3,
`endif
        DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte streams around the frame controller: UART receiver side in, framed payload out.
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output rx_data, rx_valid, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  rx_data, rx_valid, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: synchronous write, combinational read.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; a frame is only read after it has been fully written.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART RX byte stream (SYNC, LEN, payload[, CSUM]) and forwards complete frames.
// Define UART_RX_FRAME_CSUM_EN to require and check a trailing checksum byte.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 2000,
    parameter logic [7:0] SYNC    = DEFAULT_SYNC
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    uart_rx_frame_ctrl_if.slave   bus,
    output logic                  busy,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic                  overrun
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] len_q, len_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          frame_err_d, overrun_d;
    logic [1:0]    err_code_d;
    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic          timing;
`ifdef UART_RX_FRAME_CSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .CLK   (CLK),
        .we    (buf_we),
        .waddr (wr_q[AW-1:0]),
        .wdata (bus.rx_data),
        .raddr (rd_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    // Output is forced to zero outside DRAIN so unreset buffer contents never leak out.
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = bus.out_valid ? buf_rdata : 8'h00;
    assign bus.out_last  = bus.out_valid && (rd_q == len_q - PTR_ONE);
    assign busy          = (state_q != IDLE);

`ifdef UART_RX_FRAME_CSUM_EN
    assign timing = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
`else
    assign timing = (state_q == LEN) || (state_q == PAYLOAD);
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        tmr_d       = '0;
        frame_err_d = 1'b0;
        err_code_d  = err_code;
        overrun_d   = 1'b0;
        buf_we      = 1'b0;
`ifdef UART_RX_FRAME_CSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC) state_d = LEN;
            end
            LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        len_d   = bus.rx_data[PW-1:0];
                        wr_d    = '0;
                        rd_d    = '0;
`ifdef UART_RX_FRAME_CSUM_EN
                        sum_d   = bus.rx_data;
`endif
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                // SYNC here is ordinary payload data.
                if (bus.rx_valid) begin
                    buf_we = 1'b1;
                    wr_d   = wr_q + PTR_ONE;
`ifdef UART_RX_FRAME_CSUM_EN
                    sum_d  = sum_q + bus.rx_data;
                    if (wr_q == len_q - PTR_ONE) state_d = CSUM;
`else
                    if (wr_q == len_q - PTR_ONE) state_d = DRAIN;
`endif
                end
            end
`ifdef UART_RX_FRAME_CSUM_EN
            CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == sum_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
            end
`endif
            DRAIN: begin
                overrun_d = bus.rx_valid;
                if (bus.out_ready) begin
                    rd_d = rd_q + PTR_ONE;
                    if (bus.out_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only silent cycles advance the timer, so a byte on the expiry cycle always wins.
        if (timing && !bus.rx_valid) begin
            if (tmr_q == TMO_LAST) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            len_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            tmr_q     <= '0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            overrun   <= 1'b0;
`ifdef UART_RX_FRAME_CSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            tmr_q     <= tmr_d;
            frame_err <= frame_err_d;
            err_code  <= err_code_d;
            overrun   <= overrun_d;
`ifdef UART_RX_FRAME_CSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; builds with or without UART_RX_FRAME_CSUM_EN.
module tb_uart_rx_frame_ctrl;

    localparam int TMO = 2000;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       busy, frame_err, overrun;
    logic [1:0] err_code;

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl #(.MAX_LEN(16), .TIMEOUT(TMO), .SYNC(8'hA5)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .busy      (busy),
        .frame_err (frame_err),
        .err_code  (err_code),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    int vecs = 0;
    int miscompares = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int ov_cycles = 0;
    int ov0, ovr0;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } xfer_t;
    xfer_t q[$];

    // Transfers and pulses are observed just after the falling edge, when everything is settled.
    always @(negedge CLK) begin
        #1;
        if (RST_N) begin
            if (bus.out_valid) ov_cycles++;
            if (bus.out_valid && bus.out_ready) q.push_back('{d: bus.out_data, l: bus.out_last});
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge CLK);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic check_frame(input string tag, input int n,
                               input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp_b [3];
        exp_b = '{b0, b1, b2};
        #2;
        check({tag, "_cnt"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            check({tag, "_data"}, q[i].d, exp_b[i]);
            check({tag, "_last"}, q[i].l, (i == n - 1));
        end
        q.delete();
    endtask

    initial begin
        RST_N        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_code", err_code, 2'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // 1: basic three-byte frame
        send(8'hA5);
        check("t1_busy", busy, 1'b1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33);
`ifdef UART_RX_FRAME_CSUM_EN
        check("t1_wait_csum", bus.out_valid, 1'b0);
        send(8'h69);
`endif
        check("t1_latency", bus.out_valid, 1'b1);
        check("t1_first", bus.out_data, 8'h11);
        wait_idle("t1_idle");
        check_frame("t1", 3, 8'h11, 8'h22, 8'h33);
        check("t1_no_err", n_ferr, 0);

        // 2: bad lengths, then the largest legal length
        ov0 = ov_cycles;
        send(8'hA5); send(8'h00);
        check("t2a_pulse", frame_err, 1'b1);
        check("t2a_code", err_code, 2'd1);
        check("t2a_busy", busy, 1'b0);
        @(negedge CLK);
        check("t2a_clear", frame_err, 1'b0);
        send(8'hA5); send(8'h11);
        check("t2b_pulse", frame_err, 1'b1);
        check("t2b_code", err_code, 2'd1);
        repeat (2) @(negedge CLK);
        check("t2_no_out", ov_cycles, ov0);
        check("t2_nerr", n_ferr, 2);
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(i));
`ifdef UART_RX_FRAME_CSUM_EN
        send(8'h88);
`endif
        wait_idle("t2c_idle");
        #2;
        check("t2c_cnt", q.size(), 16);
        if (q.size() == 16) begin
            check("t2c_d0", q[0].d, 8'h00);
            check("t2c_l0", q[0].l, 1'b0);
            check("t2c_d15", q[15].d, 8'h0F);
            check("t2c_l15", q[15].l, 1'b1);
        end
        q.delete();

        // 3: inter-byte timeout, then a byte landing exactly on the expiry cycle
        send(8'hA5); send(8'h02); send(8'h7E);
        repeat (TMO - 1) @(negedge CLK);
        check("t3_busy_before", busy, 1'b1);
        check("t3_no_pulse_yet", frame_err, 1'b0);
        @(negedge CLK);
        check("t3_pulse", frame_err, 1'b1);
        check("t3_code", err_code, 2'd2);
        check("t3_idle", busy, 1'b0);
        send(8'hA5); send(8'h02); send(8'h7E);
        repeat (TMO - 2) @(negedge CLK);
        send(8'h7F);
        check("t3b_no_pulse", frame_err, 1'b0);
        check("t3b_busy", busy, 1'b1);
        check("t3b_code_held", err_code, 2'd2);
`ifdef UART_RX_FRAME_CSUM_EN
        send(8'hFF);
`endif
        wait_idle("t3b_idle");
        check_frame("t3b", 2, 8'h7E, 8'h7F, 8'h00);

`ifdef UART_RX_FRAME_CSUM_EN
        // 4: checksum rejection, then a good checksum
        ov0 = ov_cycles;
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'hFF);
        check("t4_pulse", frame_err, 1'b1);
        check("t4_code", err_code, 2'd3);
        check("t4_idle", busy, 1'b0);
        #2;
        check("t4_no_out", ov_cycles, ov0);
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h05);
        wait_idle("t4_idle2");
        check_frame("t4", 2, 8'h01, 8'h02, 8'h00);
`endif

        // 5: downstream stall with bytes arriving during DRAIN
        bus.out_ready = 1'b0;
        send(8'hA5); send(8'h03); send(8'hC1); send(8'hC2); send(8'hC3);
`ifdef UART_RX_FRAME_CSUM_EN
        send(8'h49);
`endif
        check("t5_valid", bus.out_valid, 1'b1);
        check("t5_data", bus.out_data, 8'hC1);
        check("t5_last", bus.out_last, 1'b0);
        ovr0 = n_ovr;
        repeat (10) @(negedge CLK);
        send(8'hA5);
        check("t5_ovr_pulse", overrun, 1'b1);
        repeat (15) @(negedge CLK);
        send(8'h55);
        repeat (15) @(negedge CLK);
        send(8'h66);
        repeat (5) @(negedge CLK);
        check("t5_hold_data", bus.out_data, 8'hC1);
        check("t5_hold_busy", busy, 1'b1);
        check("t5_ovr_count", n_ovr, ovr0 + 3);
        bus.out_ready = 1'b1;
        wait_idle("t5_idle");
        check_frame("t5", 3, 8'hC1, 8'hC2, 8'hC3);

        // 6: reset mid-payload, then a clean frame
        send(8'hA5); send(8'h04); send(8'h10); send(8'h20);
        RST_N = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_valid", bus.out_valid, 1'b0);
        check("t6_data", bus.out_data, 8'h00);
        check("t6_code", err_code, 2'd0);
        check("t6_ferr", frame_err, 1'b0);
        check("t6_ovr", overrun, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        send(8'hA5); send(8'h01); send(8'h9C);
`ifdef UART_RX_FRAME_CSUM_EN
        send(8'h9D);
`endif
        wait_idle("t6_idle");
        check_frame("t6", 1, 8'h9C, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
